// File: rtl/ibex_rf_wb_pkg.sv
// Shared types and sizing helpers for the register-file writeback stage.
package ibex_rf_wb_pkg;

    localparam int unsigned WbDataW = 32;

    typedef struct packed {
        logic               we;
        logic [4:0]         waddr;
        logic [WbDataW-1:0] wdata;
    } wb_req_t;

    function automatic int unsigned reg_addr_w(input bit rv32e);
        return rv32e ? 32'd4 : 32'd5;
    endfunction

    function automatic int unsigned num_regs(input bit rv32e);
        return 32'd1 << reg_addr_w(rv32e);
    endfunction

endpackage

// File: rtl/ibex_rf_wb_scoreboard.sv
// Pending-load bitmap: set on load issue, cleared on response, set wins on collision.
module ibex_rf_wb_scoreboard
    import ibex_rf_wb_pkg::*;
#(
    parameter bit RV32E = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       set_i,
    input  logic [4:0] set_addr_i,
    input  logic       clr_i,
    input  logic [4:0] clr_addr_i,
    input  logic [4:0] raddr_a_i,
    input  logic [4:0] raddr_b_i,
    output logic       pend_a_o,
    output logic       pend_b_o
);

    localparam int unsigned AddrW   = reg_addr_w(RV32E);
    localparam int unsigned NumRegs = num_regs(RV32E);

    logic [NumRegs-1:0] r_pending;
    logic [NumRegs-1:0] w_set_mask;
    logic [NumRegs-1:0] w_clr_mask;
    logic [AddrW-1:0]   w_set_idx;
    logic [AddrW-1:0]   w_clr_idx;
    logic [AddrW-1:0]   w_ra_idx;
    logic [AddrW-1:0]   w_rb_idx;

    assign w_set_idx = set_addr_i[AddrW-1:0];
    assign w_clr_idx = clr_addr_i[AddrW-1:0];
    assign w_ra_idx  = raddr_a_i[AddrW-1:0];
    assign w_rb_idx  = raddr_b_i[AddrW-1:0];

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (set_i && (w_set_idx != '0)) w_set_mask[w_set_idx] = 1'b1;
        if (clr_i)                      w_clr_mask[w_clr_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign pend_a_o = (w_ra_idx != '0) && r_pending[w_ra_idx];
    assign pend_b_o = (w_rb_idx != '0) && r_pending[w_rb_idx];

endmodule

// File: rtl/ibex_rf_wb_stage.sv
// Writeback merge of ALU results and LSU responses into the register file write port.
// Build option: IBEX_RF_WB_FWD_EN enables read forwarding of in-flight writes.
module ibex_rf_wb_stage
    import ibex_rf_wb_pkg::*;
#(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    input  logic                 lsu_req_i,
    input  logic [4:0]           lsu_req_waddr_i,
    input  logic                 lsu_rvalid_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    input  logic [DataWidth-1:0] rf_rdata_b_i,
    output logic [DataWidth-1:0] rdata_a_o,
    output logic [DataWidth-1:0] rdata_b_o,
    output logic                 hazard_o
);

    localparam int unsigned AddrW = reg_addr_w(RV32E);

    function automatic logic addr_nz(input logic [4:0] a);
        return a[AddrW-1:0] != '0;
    endfunction

    function automatic logic addr_eq(input logic [4:0] a, input logic [4:0] b);
        return a[AddrW-1:0] == b[AddrW-1:0];
    endfunction

    logic                 r_hold_valid;
    logic [4:0]           r_hold_waddr;
    logic [DataWidth-1:0] r_hold_wdata;
    wb_req_t              r_out;
    wb_req_t              w_sel;
    logic                 w_ex_hs;
    logic                 w_hold_cap;
    logic                 w_pend_a;
    logic                 w_pend_b;

    assign ex_ready_o = ~r_hold_valid;
    assign w_ex_hs    = ex_valid_i & ~r_hold_valid;
    assign w_hold_cap = w_ex_hs & lsu_rvalid_i;

    // Fixed priority: LSU response, then hold buffer, then new ALU result.
    always_comb begin
        w_sel = '0;
        if (lsu_rvalid_i) begin
            w_sel.we    = addr_nz(lsu_waddr_i);
            w_sel.waddr = lsu_waddr_i;
            w_sel.wdata = WbDataW'(lsu_rdata_i);
        end else if (r_hold_valid) begin
            w_sel.we    = addr_nz(r_hold_waddr);
            w_sel.waddr = r_hold_waddr;
            w_sel.wdata = WbDataW'(r_hold_wdata);
        end else if (w_ex_hs) begin
            w_sel.we    = addr_nz(ex_waddr_i);
            w_sel.waddr = ex_waddr_i;
            w_sel.wdata = WbDataW'(ex_wdata_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out        <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            r_out <= w_sel;
            if (w_hold_cap) begin
                r_hold_valid <= 1'b1;
            end else if (!lsu_rvalid_i) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_hold_cap) begin
            r_hold_waddr <= ex_waddr_i;
            r_hold_wdata <= ex_wdata_i;
        end
    end

    assign rf_we_o    = r_out.we;
    assign rf_waddr_o = r_out.waddr;
    assign rf_wdata_o = DataWidth'(r_out.wdata);

    ibex_rf_wb_scoreboard #(
        .RV32E (RV32E)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_i      (lsu_req_i),
        .set_addr_i (lsu_req_waddr_i),
        .clr_i      (lsu_rvalid_i),
        .clr_addr_i (lsu_waddr_i),
        .raddr_a_i  (raddr_a_i),
        .raddr_b_i  (raddr_b_i),
        .pend_a_o   (w_pend_a),
        .pend_b_o   (w_pend_b)
    );

`ifdef IBEX_RF_WB_FWD_EN
    function automatic logic [DataWidth-1:0] fwd_sel(
        input logic [4:0]           ra,
        input logic [DataWidth-1:0] rf,
        input logic                 hv,
        input logic [4:0]           ha,
        input logic [DataWidth-1:0] hd,
        input logic                 ov,
        input logic [4:0]           oa,
        input logic [DataWidth-1:0] od
    );
        if (!addr_nz(ra))           return rf;
        if (hv && addr_eq(ra, ha))  return hd;
        if (ov && addr_eq(ra, oa))  return od;
        return rf;
    endfunction

    assign rdata_a_o = fwd_sel(raddr_a_i, rf_rdata_a_i, r_hold_valid, r_hold_waddr,
                               r_hold_wdata, rf_we_o, rf_waddr_o, rf_wdata_o);
    assign rdata_b_o = fwd_sel(raddr_b_i, rf_rdata_b_i, r_hold_valid, r_hold_waddr,
                               r_hold_wdata, rf_we_o, rf_waddr_o, rf_wdata_o);
    assign hazard_o  = w_pend_a | w_pend_b;
`else
    // Without forwarding, any uncommitted write to a read register stalls decode.
    function automatic logic in_flight(
        input logic [4:0] ra,
        input logic       hv,
        input logic [4:0] ha,
        input logic       ov,
        input logic [4:0] oa
    );
        return addr_nz(ra) && ((hv && addr_eq(ra, ha)) || (ov && addr_eq(ra, oa)));
    endfunction

    assign rdata_a_o = rf_rdata_a_i;
    assign rdata_b_o = rf_rdata_b_i;
    assign hazard_o  = w_pend_a | w_pend_b
                     | in_flight(raddr_a_i, r_hold_valid, r_hold_waddr, rf_we_o, rf_waddr_o)
                     | in_flight(raddr_b_i, r_hold_valid, r_hold_waddr, rf_we_o, rf_waddr_o);
`endif

endmodule

// File: tb/tb_ibex_rf_wb_stage.sv
// Directed bench for ibex_rf_wb_stage; checks adapt to IBEX_RF_WB_FWD_EN.
module tb_ibex_rf_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        lsu_req;
    logic [4:0]  lsu_req_waddr;
    logic        lsu_rvalid;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] rf_rdata_a;
    logic [31:0] rf_rdata_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        hazard;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ibex_rf_wb_stage #(
        .RV32E     (1'b0),
        .DataWidth (32)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ex_valid_i      (ex_valid),
        .ex_ready_o      (ex_ready),
        .ex_waddr_i      (ex_waddr),
        .ex_wdata_i      (ex_wdata),
        .lsu_req_i       (lsu_req),
        .lsu_req_waddr_i (lsu_req_waddr),
        .lsu_rvalid_i    (lsu_rvalid),
        .lsu_waddr_i     (lsu_waddr),
        .lsu_rdata_i     (lsu_rdata),
        .rf_we_o         (rf_we),
        .rf_waddr_o      (rf_waddr),
        .rf_wdata_o      (rf_wdata),
        .raddr_a_i       (raddr_a),
        .raddr_b_i       (raddr_b),
        .rf_rdata_a_i    (rf_rdata_a),
        .rf_rdata_b_i    (rf_rdata_b),
        .rdata_a_o       (rdata_a),
        .rdata_b_o       (rdata_b),
        .hazard_o        (hazard)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid   = 1'b0;
        lsu_req    = 1'b0;
        lsu_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        ex_waddr = 5'd0;  ex_wdata = 32'h0;
        lsu_req_waddr = 5'd0;  lsu_waddr = 5'd0;  lsu_rdata = 32'h0;
        raddr_a = 5'd0;  raddr_b = 5'd0;
        rf_rdata_a = 32'h0;  rf_rdata_b = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_we",    32'(rf_we),    32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata,      32'd0);
        chk("rst_ready", 32'(ex_ready), 32'd1);
        chk("rst_hazard", 32'(hazard),  32'd0);
        rst = 1'b0;
        tick();

        // Plain ALU write x5, then read x5 on port b while RF data is stale
        ex_valid = 1'b1;  ex_waddr = 5'd5;  ex_wdata = 32'hDEADBEEF;
        tick();
        idle();
        raddr_b = 5'd5;  rf_rdata_b = 32'h00001234;
        #1;
        chk("alu_we",    32'(rf_we),    32'd1);
        chk("alu_waddr", 32'(rf_waddr), 32'd5);
        chk("alu_wdata", rf_wdata,      32'hDEADBEEF);
        chk("alu_ready", 32'(ex_ready), 32'd1);
`ifdef IBEX_RF_WB_FWD_EN
        chk("fwd_rdata_b",  rdata_b,      32'hDEADBEEF);
        chk("fwd_hazard",   32'(hazard),  32'd0);
`else
        chk("nofwd_rdata_b", rdata_b,     32'h00001234);
        chk("nofwd_hazard",  32'(hazard), 32'd1);
`endif
        tick();
        chk("alu_we_drop", 32'(rf_we), 32'd0);
        chk("alu_hz_drop", 32'(hazard), 32'd0);
        raddr_b = 5'd0;

        // LSU response and ALU result collide
        lsu_rvalid = 1'b1;  lsu_waddr = 5'd7;  lsu_rdata = 32'h11;
        ex_valid = 1'b1;  ex_waddr = 5'd8;  ex_wdata = 32'h22;
        #1;
        chk("col_ready_pre", 32'(ex_ready), 32'd1);
        tick();
        idle();
        raddr_a = 5'd8;  rf_rdata_a = 32'h0000AAAA;
        #1;
        chk("col_waddr1", 32'(rf_waddr), 32'd7);
        chk("col_wdata1", rf_wdata,      32'h11);
        chk("col_ready1", 32'(ex_ready), 32'd0);
`ifdef IBEX_RF_WB_FWD_EN
        chk("col_fwd_hold", rdata_a,      32'h22);
        chk("col_hazard",   32'(hazard),  32'd0);
`else
        chk("col_hazard",   32'(hazard),  32'd1);
`endif
        tick();
        chk("col_we2",    32'(rf_we),    32'd1);
        chk("col_waddr2", 32'(rf_waddr), 32'd8);
        chk("col_wdata2", rf_wdata,      32'h22);
        chk("col_ready2", 32'(ex_ready), 32'd1);
        tick();
        chk("col_we3", 32'(rf_we), 32'd0);
        raddr_a = 5'd0;

        // Scoreboard on x9
        lsu_req = 1'b1;  lsu_req_waddr = 5'd9;
        tick();
        idle();
        raddr_a = 5'd9;
        #1;
        chk("sb_hz_set", 32'(hazard), 32'd1);
        tick();
        chk("sb_hz_hold", 32'(hazard), 32'd1);
        lsu_rvalid = 1'b1;  lsu_waddr = 5'd9;  lsu_rdata = 32'h99;
        lsu_req = 1'b1;  lsu_req_waddr = 5'd9;
        tick();
        idle();
        #1;
        chk("sb_set_wins", 32'(hazard),   32'd1);
        chk("sb_rsp_addr", 32'(rf_waddr), 32'd9);
        chk("sb_rsp_data", rf_wdata,      32'h99);
        lsu_rvalid = 1'b1;  lsu_waddr = 5'd9;  lsu_rdata = 32'h9A;
        tick();
        idle();
        #1;
`ifdef IBEX_RF_WB_FWD_EN
        chk("sb_clr", 32'(hazard), 32'd0);
`else
        chk("sb_clr_inflight", 32'(hazard), 32'd1);
`endif
        tick();
        chk("sb_clr_done", 32'(hazard), 32'd0);
        raddr_a = 5'd0;

        // Write to x0 and read of x0
        ex_valid = 1'b1;  ex_waddr = 5'd0;  ex_wdata = 32'h0000FFFF;
        tick();
        idle();
        raddr_a = 5'd0;  rf_rdata_a = 32'h0000ABCD;
        raddr_b = 5'd0;  rf_rdata_b = 32'h00005678;
        #1;
        chk("x0_we",      32'(rf_we),  32'd0);
        chk("x0_rdata_a", rdata_a,     32'h0000ABCD);
        chk("x0_rdata_b", rdata_b,     32'h00005678);
        chk("x0_hazard",  32'(hazard), 32'd0);
        tick();

        // Reset while hold is valid and x4 is pending; LSU response during reset dropped
        lsu_req = 1'b1;  lsu_req_waddr = 5'd4;
        tick();
        idle();
        lsu_rvalid = 1'b1;  lsu_waddr = 5'd7;  lsu_rdata = 32'h77;
        ex_valid = 1'b1;  ex_waddr = 5'd6;  ex_wdata = 32'h66;
        tick();
        idle();
        raddr_a = 5'd4;
        #1;
        chk("pre_rst_ready",  32'(ex_ready), 32'd0);
        chk("pre_rst_hazard", 32'(hazard),   32'd1);
        rst = 1'b1;
        lsu_rvalid = 1'b1;  lsu_waddr = 5'd12;  lsu_rdata = 32'h0C;
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("post_rst_ready",  32'(ex_ready), 32'd1);
        chk("post_rst_hazard", 32'(hazard),   32'd0);
        chk("post_rst_we",     32'(rf_we),    32'd0);
        tick();
        chk("post_rst_no_drain", 32'(rf_we), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ibex_rf_wb_stage.md
# ibex_rf_wb_stage

Writeback stage directly upstream of the FPGA register file's single write port. It merges ALU results and in-order LSU load responses into one registered write per cycle, holds a displaced ALU result in a one-entry buffer, and tracks outstanding loads in a scoreboard. Optional read-port forwarding covers writes that are in flight but not yet committed. Its outputs drive the register file's write address, data and enable ports; its forwarded read data replaces the register file read data at the decode stage.

## Interface
- RV32E, 0: 16 architectural registers when 1 (scoreboard width 16, address bit 4 ignored), 32 otherwise.
- DataWidth, 32: data width of all data ports.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- ex_valid_i  in  1  ALU result valid.
- ex_ready_o  out  1  ALU result accepted; equals !hold_valid.
- ex_waddr_i  in  5  ALU destination register.
- ex_wdata_i  in  DataWidth  ALU result.
- lsu_req_i  in  1  load issued; marks its destination pending.
- lsu_req_waddr_i  in  5  destination register of the issued load.
- lsu_rvalid_i  in  1  load response; cannot be back-pressured.
- lsu_waddr_i  in  5  response destination, in issue order.
- lsu_rdata_i  in  DataWidth  load data.
- rf_we_o  out  1  register file write enable (registered).
- rf_waddr_o  out  5  register file write address (registered).
- rf_wdata_o  out  DataWidth  register file write data (registered).
- raddr_a_i, raddr_b_i  in  5  decode read addresses.
- rf_rdata_a_i, rf_rdata_b_i  in  DataWidth  register file read data.
- rdata_a_o, rdata_b_o  out  DataWidth  forwarded read data.
- hazard_o  out  1  decode must stall; combinational.

## Operation
- Arbitration is by fixed priority: LSU response > hold buffer > new ALU result.
- A write is accepted from the winning source into the output register (rf_*_o) each cycle. Writes to x0 are accepted, but rf_we_o stays 0 for them.
- If an ALU handshake (ex_valid_i && ex_ready_o) loses to lsu_rvalid_i, the ALU result is captured into the hold buffer and hold_valid is set.
- If hold is valid and there is no LSU response, hold drains to the output register. The ALU handshake is blocked in that cycle because ex_ready_o=0.
- If hold is valid and an LSU response arrives, hold persists.
- Scoreboard: pending[lsu_req_waddr_i] is set on lsu_req_i (never for x0). pending[lsu_waddr_i] is cleared when the response is accepted. When a set and a clear hit the same index in the same cycle, set wins.
- hazard_o is asserted when pending[raddr_a_i] or pending[raddr_b_i] is set, for nonzero addresses.
- Forwarding priority per port: hold buffer match, then output register match (rf_we_o), then rf_rdata_*_i. Reads of x0 pass rf_rdata_*_i through.

## Timing
- Write latency is one cycle from the accepting edge to rf_we_o. The register file commits on the following edge.
- ex_ready_o depends only on state (no combinational path from ex_valid_i).
- Reset values: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, hold_valid=0 (so ex_ready_o=1), pending all 0. hazard_o is therefore 0 after reset.
- Reset asserted mid-operation discards hold contents and pending bits in the same cycle. An LSU response arriving during reset is dropped.

## Configuration
- IBEX_RF_WB_FWD_EN defined: forwarding as described.
- IBEX_RF_WB_FWD_EN undefined:
  - rdata_*_o equal rf_rdata_*_i.
  - hazard_o is additionally asserted when a nonzero read address matches the valid hold buffer, or matches rf_waddr_o while rf_we_o=1.

## Structure
- Package ibex_rf_wb_pkg holds:
  - wb_req_t struct {we, waddr[4:0], wdata}.
  - the RegAddrW / NumRegs helper function of RV32E.
- Sub-module ibex_rf_wb_scoreboard contains the pending bitmap, the set/clear logic and the two hazard lookups.

## Test plan
- ALU write x5=0xDEADBEEF, no LSU activity -> rf_we_o=1, rf_waddr_o=5 one cycle later, and ex_ready_o stays 1.
- lsu_rvalid_i (x7=0x11) and ALU (x8=0x22) in the same cycle -> cycle+1 writes x7, cycle+2 writes x8, and ex_ready_o=0 for exactly one cycle.
- lsu_req_i to x9, then read raddr_a_i=9 -> hazard_o=1 until the response is accepted, then 0. A clear coinciding with a new load to x9 keeps hazard_o=1.
- With FWD_EN, ALU x3=0x55 and raddr_b_i=3 on the next cycle -> rdata_b_o=0x55 while rf_rdata_b_i is still stale. Without FWD_EN -> hazard_o=1 for that cycle.
- Write to x0 with data 0xFFFF -> rf_we_o stays 0, and a read of x0 returns rf_rdata_*_i unchanged.
- rst_i pulsed while hold is valid and x4 is pending -> next cycle ex_ready_o=1, hazard_o=0 for raddr 4, rf_we_o=0.
